csa_stream_accumulator: RTL and testbench
=========================================

# csa_stream_accumulator

Sequential counterpart of the combinational multi-operand adder tree. Accepts a stream of COUNT operands, one per cycle, over a valid/ready handshake. Folds each operand into a registered carry-save pair with a single 3:2 compressor row, then resolves the pair with one carry-propagate add. Presents the full-precision sum downstream over a second valid/ready handshake, so operand banks no longer need to arrive in parallel.

## Interface
- WIDTH, 7, operand width in bits.
- COUNT, 8, operands per sum; power of two, at least 2.
- OUT_WIDTH, WIDTH + $clog2(COUNT) (10 by default), result width; sized so the result never overflows.
- clk  input  1  rising-edge clock.
- rst_n  input  1  reset; one clock; reset is asynchronous and active-low.
- in_valid  input  1  operand valid.
- in_ready  output  1  operand ready; high only in ACCUM.
- in_data  input  WIDTH  operand.
- abort  input  1  synchronous discard of all work in progress.
- out_valid  output  1  result valid.
- out_ready  input  1  downstream ready.
- out_sum  output  OUT_WIDTH  resolved sum.
- op_count  output  $clog2(COUNT)+1  operands accepted in the current group.

## Operation
- Reset values: state=ACCUM, sum/carry vectors=0, op_count=0, out_valid=0, out_sum=0, in_ready=1.
- Operands are extended to OUT_WIDTH before use: zero-extension by default, sign-extension per Configuration.
- ACCUM:
  - in_ready=1.
  - On a handshake (in_valid & in_ready), the registers update to (S,C) <= CSA(S, C<<1, ext(in_data)).
  - The carry that shifts out of bit OUT_WIDTH-1 is dropped. This is exact modulo 2^OUT_WIDTH.
  - op_count increments on each handshake.
  - On the handshake that makes op_count equal COUNT, the next state is RESOLVE.
- RESOLVE:
  - Lasts exactly one cycle; in_ready=0.
  - out_sum <= S + (C<<1), truncated to OUT_WIDTH.
  - S, C and op_count clear. Next state is HOLD.
- HOLD:
  - out_valid=1, in_ready=0.
  - out_sum is held stable until out_valid & out_ready. Then out_valid clears and the next state is ACCUM.
- abort:
  - Honoured in every state and overrides all other transitions.
  - Next cycle: state=ACCUM, S=C=0, op_count=0, out_valid=0.
  - An operand presented in the same cycle as abort is discarded. in_ready may read 1 that cycle, but the operand is not counted.
  - abort in the same cycle as an output handshake: the transfer is complete, and the block still returns to ACCUM cleared.
  - out_sum keeps its last value after an abort; it is don't-care while out_valid=0.
- Idle cycles with in_valid=0 in ACCUM leave all state unchanged. Gaps between operands are allowed.

## Timing
- 8th (COUNT-th) input handshake at cycle T: RESOLVE during T+1; out_valid=1 from T+2.
- Output handshake at cycle H: in_ready=1 at H+1.
- Minimum period per result is COUNT+2 cycles (10 by default): COUNT ACCUM cycles, 1 RESOLVE cycle, at least 1 HOLD cycle.
- No combinational path from in_valid to in_ready, or from out_ready to out_valid.
- in_ready depends only on state, except during the abort cycle.
- Critical path: one full-adder level in ACCUM; an OUT_WIDTH ripple add in RESOLVE.

## Configuration
- CSA_ACC_SIGNED_EN defined:
  - Operands are two's complement and sign-extended to OUT_WIDTH.
  - out_sum is two's complement. Default range is -512..504.
- CSA_ACC_SIGNED_EN undefined:
  - Operands are unsigned and zero-extended.
  - out_sum is unsigned. Default range is 0..1016.

## Structure
- Package csa_acc_pkg holds:
  - the state enum (ACCUM, RESOLVE, HOLD);
  - the default WIDTH/COUNT constants;
  - an out-width helper function.
- Sub-module csa_row: an OUT_WIDTH-wide row of full adders (3:2 compressor), instantiated once for the ACCUM update.
- The top level holds the FSM, op_count, the S/C registers, and the RESOLVE adder.

## Test plan
- Unsigned build, operands 1..8 back-to-back, out_ready=1:
  - out_valid rises 2 cycles after the 8th handshake;
  - out_sum=36;
  - in_ready returns high the cycle after the output handshake.
- Unsigned build, eight operands of 127 with random in_valid gaps: out_sum=1016, with no overflow.
- Backpressure: out_ready low for 5 cycles in HOLD.
  - out_sum stays stable and out_valid stays high;
  - in_ready stays 0 and in_data is ignored;
  - the result is released on the first out_ready=1.
- Abort: abort asserted after 3 operands (with an operand offered the same cycle), then eight operands of 5.
  - op_count reads 0 after the abort;
  - out_sum=40.
- Reset mid-group: rst_n dropped after 5 operands.
  - All outputs return to reset values immediately;
  - the next full group of eight operands of 1 yields 8.
- Signed build: eight operands of 7'h40 yield out_sum=10'h200 (-512); operands 63,-1,…(alternating) sum correctly.

Source files
------------

// File: rtl/csa_acc_pkg.sv
// Shared types and sizing for the carry-save stream accumulator.
// Build option: CSA_ACC_SIGNED_EN selects two's complement operands.
package csa_acc_pkg;

  localparam int DEF_WIDTH = 7;
  localparam int DEF_COUNT = 8;

  typedef enum logic [1:0] {
    ACCUM,
    RESOLVE,
    HOLD
  } state_e;

  function automatic int out_width(
    input int w,
    input int c
  );
    return w + $clog2(c);
  endfunction

endpackage

// File: rtl/csa_stream_accumulator_if.sv
// Operand and result handshakes of the stream accumulator.
// master drives operands and accepts results; slave is the block.
interface csa_stream_accumulator_if
  import csa_acc_pkg::*;
#(
  parameter int WIDTH     = DEF_WIDTH,
  parameter int COUNT     = DEF_COUNT,
  parameter int OUT_WIDTH = out_width(WIDTH, COUNT),
  parameter int CW        = $clog2(COUNT) + 1
);

  logic                 in_valid;
  logic                 in_ready;
  logic [WIDTH-1:0]     in_data;
  logic                 abort;
  logic                 out_valid;
  logic                 out_ready;
  logic [OUT_WIDTH-1:0] out_sum;
  logic [CW-1:0]        op_count;

  modport master (
    output in_valid,
    output in_data,
    output abort,
    output out_ready,
    input  in_ready,
    input  out_valid,
    input  out_sum,
    input  op_count
  );

  modport slave (
    input  in_valid,
    input  in_data,
    input  abort,
    input  out_ready,
    output in_ready,
    output out_valid,
    output out_sum,
    output op_count
  );

endinterface

// File: rtl/csa_row.sv
// One row of full adders: a 3:2 compressor of W-bit vectors.
// Carry bit i has weight 2^(i+1); the caller shifts it.
module csa_row #(
  parameter int W = 10
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic [W-1:0] c,
  output logic [W-1:0] s,
  output logic [W-1:0] co
);

  assign s  = a ^ b ^ c;
  assign co = (a & b) | (a & c) | (b & c);

endmodule

// File: rtl/csa_stream_accumulator.sv
// Streams COUNT operands into a carry-save pair, resolves once per group.
// Build option: CSA_ACC_SIGNED_EN sign-extends operands.
module csa_stream_accumulator
  import csa_acc_pkg::*;
#(
  parameter int WIDTH     = DEF_WIDTH,
  parameter int COUNT     = DEF_COUNT,
  parameter int OUT_WIDTH = out_width(WIDTH, COUNT),
  parameter int CW        = $clog2(COUNT) + 1
) (
  input logic                     clk,
  input logic                     rst_n,
  csa_stream_accumulator_if.slave bus
);

  state_e               state_q;
  state_e               state_d;
  logic [OUT_WIDTH-1:0] s_q;
  logic [OUT_WIDTH-1:0] c_q;
  logic [OUT_WIDTH-1:0] c_sh;
  logic [OUT_WIDTH-1:0] ext;
  logic [OUT_WIDTH-1:0] row_s;
  logic [OUT_WIDTH-1:0] row_c;
  logic [OUT_WIDTH-1:0] sum_q;
  logic [CW-1:0]        cnt_q;
  logic                 rdy;
  logic                 hs_in;
  logic                 last;

`ifdef CSA_ACC_SIGNED_EN
  assign ext = {{(OUT_WIDTH-WIDTH){bus.in_data[WIDTH-1]}},
                bus.in_data};
`else
  assign ext = {{(OUT_WIDTH-WIDTH){1'b0}}, bus.in_data};
`endif

  // carry out of the top bit is dropped: exact mod 2^OUT_WIDTH
  assign c_sh  = {c_q[OUT_WIDTH-2:0], 1'b0};
  assign rdy   = (state_q == ACCUM);
  assign hs_in = bus.in_valid & rdy & ~bus.abort;
  assign last  = hs_in & (cnt_q == CW'(COUNT - 1));

  csa_row #(.W(OUT_WIDTH)) u_row (
    .a  (s_q),
    .b  (c_sh),
    .c  (ext),
    .s  (row_s),
    .co (row_c)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ACCUM;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    if (bus.abort) begin
      state_d = ACCUM;
    end else begin
      unique case (state_q)
        ACCUM:   if (last) state_d = RESOLVE;
        RESOLVE: state_d = HOLD;
        HOLD:    if (bus.out_ready) state_d = ACCUM;
        default: state_d = ACCUM;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s_q   <= '0;
      c_q   <= '0;
      cnt_q <= '0;
      sum_q <= '0;
    end else if (bus.abort) begin
      s_q   <= '0;
      c_q   <= '0;
      cnt_q <= '0;
    end else if (state_q == ACCUM) begin
      if (hs_in) begin
        s_q   <= row_s;
        c_q   <= row_c;
        cnt_q <= cnt_q + 1'b1;
      end
    end else if (state_q == RESOLVE) begin
      sum_q <= s_q + c_sh;
      s_q   <= '0;
      c_q   <= '0;
      cnt_q <= '0;
    end
  end

  assign bus.in_ready  = rdy;
  assign bus.out_valid = (state_q == HOLD);
  assign bus.out_sum   = sum_q;
  assign bus.op_count  = cnt_q;

endmodule

// File: tb/tb_csa_stream_accumulator.sv
// Scoreboard bench for csa_stream_accumulator.
// Signed vectors run when CSA_ACC_SIGNED_EN is defined.
module tb_csa_stream_accumulator;

  logic clk;
  logic rst_n;
  int   checks;
  int   errors;
  int   exp_q[$];
  int   exp_sum;

  csa_stream_accumulator_if bus ();

  csa_stream_accumulator dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  // results are compared whenever a transfer happens
  always @(negedge clk) begin
    if (rst_n && bus.out_valid && bus.out_ready) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_result: got %0d expected none",
                 bus.out_sum);
      end else begin
        exp_sum = exp_q.pop_front();
        chk("out_sum", int'(bus.out_sum), exp_sum);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [6:0] d);
    int n = 0;
    bus.in_valid = 1'b1;
    bus.in_data  = d;
    while (!bus.in_ready && n < 50) begin
      tick();
      n++;
    end
    if (!bus.in_ready) chk("in_ready_timeout", 0, 1);
    tick();
    bus.in_valid = 1'b0;
  endtask

  task automatic run_group(input logic [6:0] v[8],
                           input int gap, input int exp);
    exp_q.push_back(exp);
    for (int i = 0; i < 8; i++) begin
      send(v[i]);
      if (i < 7) repeat (gap + (i % 2)) tick();
    end
  endtask

  task automatic run_const(input logic [6:0] d,
                           input int gap, input int exp);
    logic [6:0] v[8];
    for (int i = 0; i < 8; i++) v[i] = d;
    run_group(v, gap, exp);
  endtask

  task automatic wait_out();
    int n = 0;
    while (!bus.out_valid && n < 50) begin
      tick();
      n++;
    end
    if (!bus.out_valid) chk("out_valid_timeout", 0, 1);
  endtask

  task automatic drain();
    wait_out();
    tick();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    checks        = 0;
    errors        = 0;
    rst_n         = 1'b0;
    bus.in_valid  = 1'b0;
    bus.in_data   = '0;
    bus.abort     = 1'b0;
    bus.out_ready = 1'b1;
    #12;
    chk("rst_op_count", int'(bus.op_count), 0);
    chk("rst_out_valid", int'(bus.out_valid), 0);
    chk("rst_in_ready", int'(bus.in_ready), 1);
    chk("rst_out_sum", int'(bus.out_sum), 0);
    rst_n = 1'b1;
    tick();

    // 1..8 back to back, latency and ready return
    run_group('{7'd1, 7'd2, 7'd3, 7'd4,
                7'd5, 7'd6, 7'd7, 7'd8}, -1, 36);
    chk("t1_resolve_valid", int'(bus.out_valid), 0);
    chk("t1_resolve_ready", int'(bus.in_ready), 0);
    tick();
    chk("t1_hold_valid", int'(bus.out_valid), 1);
    chk("t1_hold_sum", int'(bus.out_sum), 36);
    tick();
    chk("t1_ready_back", int'(bus.in_ready), 1);
    chk("t1_valid_clear", int'(bus.out_valid), 0);

`ifdef CSA_ACC_SIGNED_EN
    run_const(7'h40, 0, 512);
    drain();
    run_group('{7'h3f, 7'h7f, 7'h3f, 7'h7f,
                7'h3f, 7'h7f, 7'h3f, 7'h7f}, 1, 248);
    drain();
`else
    run_const(7'd127, 1, 1016);
    drain();
`endif

    // backpressure in HOLD
    bus.out_ready = 1'b0;
    run_group('{7'd2, 7'd4, 7'd6, 7'd8,
                7'd10, 7'd12, 7'd14, 7'd16}, -1, 72);
    wait_out();
    for (int i = 0; i < 5; i++) begin
      chk("bp_valid", int'(bus.out_valid), 1);
      chk("bp_sum", int'(bus.out_sum), 72);
      chk("bp_ready", int'(bus.in_ready), 0);
      bus.in_valid = 1'b1;
      bus.in_data  = 7'd33;
      tick();
    end
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    chk("bp_valid_last", int'(bus.out_valid), 1);
    tick();
    chk("bp_ready_back", int'(bus.in_ready), 1);
    chk("bp_count", int'(bus.op_count), 0);

    // abort after 3 operands, with one offered alongside
    for (int i = 0; i < 3; i++) send(7'd9);
    chk("ab_count_pre", int'(bus.op_count), 3);
    bus.in_valid = 1'b1;
    bus.in_data  = 7'd50;
    bus.abort    = 1'b1;
    tick();
    bus.abort    = 1'b0;
    bus.in_valid = 1'b0;
    chk("ab_count", int'(bus.op_count), 0);
    chk("ab_valid", int'(bus.out_valid), 0);
    chk("ab_ready", int'(bus.in_ready), 1);
    run_const(7'd5, 0, 40);
    drain();

    // asynchronous reset mid-group
    for (int i = 0; i < 5; i++) send(7'd3);
    chk("rs_count_pre", int'(bus.op_count), 5);
    #2;
    rst_n = 1'b0;
    #1;
    chk("rs_count", int'(bus.op_count), 0);
    chk("rs_valid", int'(bus.out_valid), 0);
    chk("rs_ready", int'(bus.in_ready), 1);
    chk("rs_sum", int'(bus.out_sum), 0);
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    run_const(7'd1, 0, 8);
    drain();

    repeat (3) tick();
    chk("queue_empty", exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
